// File: rtl/partselect_pkg.sv
// Shared widths and helpers for the part-select stream wrapper.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default widths, sel_bits() used for both selects, out_w() for the result width.
package partselect_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IDX_W_DEF  = 4;
  localparam int SEL1_W_DEF = 4;
  localparam int SEL2_W_DEF = 3;
  localparam int DEPTH_DEF  = 4;
  localparam int WRAP_DEF   = 0;
  localparam int CNT_W_DEF  = 8;

  // Widest data word sel_bits() can handle; DATA_W must not exceed this.
  localparam int SEL_MAX = 64;

  // Returns data[idx +: w] in the low w bits. Positions at or beyond data_w read
  // as 0, or wrap modulo data_w when wrap is set.
  function automatic logic [SEL_MAX-1:0] sel_bits(input logic [SEL_MAX-1:0] data,
                                                  input int data_w,
                                                  input int idx,
                                                  input int w,
                                                  input bit wrap);
    logic [SEL_MAX-1:0] r;
    int p;
    int pm;
    r = '0;
    for (int k = 0; k < SEL_MAX; k++) begin
      p  = idx + k;
      pm = p % data_w;
      if (k < w) begin
        if (p < data_w) begin
          r[k] = data[p[5:0]];
        end else if (wrap) begin
          r[k] = data[pm[5:0]];
        end
      end
    end
    return r;
  endfunction

  function automatic int out_w(input int s1w = SEL1_W_DEF, input int s2w = SEL2_W_DEF);
    return s1w + s2w + 1;
  endfunction

endpackage

// File: rtl/partselect_stream_wrapper_if.sv
// Stream bundle between the fuzz harness and the part-select wrapper.
// Latency: n/a (wires only). Backpressure: in_ready/out_ready carried here.
// Ports: in_flat/in_valid/in_ready, out_flat/out_valid/out_ready, ovf_clr, ovf_count.
interface partselect_stream_wrapper_if
  import partselect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int SEL1_W = SEL1_W_DEF,
  parameter int SEL2_W = SEL2_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int OUT_W = out_w(SEL1_W, SEL2_W);

  logic [2*DATA_W+IDX_W-1:0] in_flat;
  logic                      in_valid;
  logic                      in_ready;
  logic [OUT_W-1:0]          out_flat;
  logic                      out_valid;
  logic                      out_ready;
  logic                      ovf_clr;
  logic [CNT_W-1:0]          ovf_count;

  // master: the stream producer/consumer; slave: the wrapper.
  modport master (
    output in_flat, in_valid, out_ready, ovf_clr,
    input  in_ready, out_flat, out_valid, ovf_count
  );

  modport slave (
    input  in_flat, in_valid, out_ready, ovf_clr,
    output in_ready, out_flat, out_valid, ovf_count
  );

endinterface

// File: rtl/partselect_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is 0 while empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored while full (even if popping), pop ignored while empty.
// Ports: clk, rst_n, push/push_dat, pop, head, full, empty.
module partselect_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/partselect_stream_wrapper.sv
// Part-select of data1/data2 at idx with overflow flag, buffered in an output FIFO.
// Latency: 2 cycles minimum (compute register s1, then FIFO head).
// Backpressure: s1 holds while the FIFO is full; in_ready = !s1_valid || !fifo_full.
// Ports: clk, rst_n, bus (slave side of partselect_stream_wrapper_if).
module partselect_stream_wrapper
  import partselect_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int SEL1_W    = SEL1_W_DEF,
  parameter int SEL2_W    = SEL2_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int WRAP_MODE = WRAP_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  partselect_stream_wrapper_if.slave bus
);
  localparam int OUT_W = out_w(SEL1_W, SEL2_W);
  localparam int IN_W  = 2*DATA_W + IDX_W;

  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [IDX_W-1:0]  idx;
  logic [SEL1_W-1:0] sel1;
  logic [SEL2_W-1:0] sel2;
  logic              ovf;
  logic [OUT_W-1:0]  comp_dat;

  logic              s1_valid;
  logic [OUT_W-1:0]  s1_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_ready;
  logic              in_hs;
  logic [CNT_W-1:0]  ovf_cnt;

  assign data1 = bus.in_flat[IN_W-1 -: DATA_W];
  assign data2 = bus.in_flat[IDX_W +: DATA_W];
  assign idx   = bus.in_flat[IDX_W-1:0];

  // Sums done in 32-bit int so idx + width can never wrap.
  assign ovf = (int'(idx) + SEL1_W > DATA_W) || (int'(idx) + SEL2_W > DATA_W);

  assign sel1 = SEL1_W'(sel_bits(SEL_MAX'(data1), DATA_W, int'(idx), SEL1_W, WRAP_MODE != 0));
  assign sel2 = SEL2_W'(sel_bits(SEL_MAX'(data2), DATA_W, int'(idx), SEL2_W, WRAP_MODE != 0));
  assign comp_dat = {sel1, sel2, ovf};

  // Registered state only: no path from in_valid or out_ready.
  assign in_ready     = !s1_valid || !fifo_full;
  assign bus.in_ready = in_ready;
  assign in_hs        = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dat   <= '0;
    end else if (in_hs) begin
      s1_valid <= 1'b1;
      s1_dat   <= comp_dat;
    end else if (s1_valid && !fifo_full) begin
      s1_valid <= 1'b0;
    end
  end

  partselect_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s1_valid),
    .push_dat (s1_dat),
    .pop      (bus.out_ready),
    .head     (bus.out_flat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;

  // Clear takes priority over a same-cycle increment; increment saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (bus.ovf_clr) begin
      ovf_cnt <= '0;
    end else if (in_hs && ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  assign bus.ovf_count = ovf_cnt;

endmodule
